// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter
// Two requesters share one external combinational adder. A round-robin
// grant picks one pending request while idle. Its operands are registered
// towards the adder. One cycle later the sum is captured, and the result
// is then held until the consumer takes it. At most one operation is in
// flight at a time.
module shared_adder_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] add_a_q;
    logic [WIDTH-1:0] add_a_d;
    logic [WIDTH-1:0] add_b_q;
    logic [WIDTH-1:0] add_b_d;
    logic             add_cin_q;
    logic             add_cin_d;
    logic             op_id_q;
    logic             op_id_d;
    logic             last_grant_q;
    logic             last_grant_d;
    logic [WIDTH-1:0] rsp_sum_q;
    logic [WIDTH-1:0] rsp_sum_d;
    logic             rsp_id_q;
    logic             rsp_id_d;

    logic             grant_valid_s;
    logic             grant_id_s;

    // Grant decision: only while idle; a contested grant goes to the requester not served last.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (state_q == IDLE) begin
            case ({req1_valid, req0_valid})
                2'b01: begin
                    grant_valid_s = 1'b1;
                    grant_id_s    = 1'b0;
                end
                2'b10: begin
                    grant_valid_s = 1'b1;
                    grant_id_s    = 1'b1;
                end
                2'b11: begin
                    grant_valid_s = 1'b1;
                    grant_id_s    = ~last_grant_q;
                end
                default: begin
                    grant_valid_s = 1'b0;
                    grant_id_s    = 1'b0;
                end
            endcase
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. A granted request is always accepted because ready follows the grant.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: ready only to the granted requester, valid only while holding a result.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        if (grant_valid_s) begin
            req0_ready = ~grant_id_s;
            req1_ready = grant_id_s;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
        if (state_q == RESP) begin
            rsp_valid = 1'b1;
        end else begin
            rsp_valid = 1'b0;
        end
    end

    // Datapath next values: load operands on accept, capture the adder result in EXEC, otherwise hold.
    always_comb begin
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_cin_d    = add_cin_q;
        op_id_d      = op_id_q;
        last_grant_d = last_grant_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_id_d     = rsp_id_q;
        if (grant_valid_s) begin
            add_a_d      = grant_id_s ? req1_a   : req0_a;
            add_b_d      = grant_id_s ? req1_b   : req0_b;
            add_cin_d    = grant_id_s ? req1_cin : req0_cin;
            op_id_d      = grant_id_s;
            last_grant_d = grant_id_s;
        end else if (state_q == EXEC) begin
            rsp_sum_d = add_sum;
            rsp_id_d  = op_id_q;
        end else begin
            rsp_sum_d = rsp_sum_q;
            rsp_id_d  = rsp_id_q;
        end
    end

    // Datapath registers. Reset leaves last_grant at 1 so the first contested grant goes to requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_a_q      <= {WIDTH{1'b0}};
            add_b_q      <= {WIDTH{1'b0}};
            add_cin_q    <= 1'b0;
            op_id_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_sum_q    <= {WIDTH{1'b0}};
            rsp_id_q     <= 1'b0;
        end else begin
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_cin_q    <= add_cin_d;
            op_id_q      <= op_id_d;
            last_grant_q <= last_grant_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_cin = add_cin_q;
    assign rsp_sum = rsp_sum_q;
    assign rsp_id  = rsp_id_q;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Scoreboard bench for shared_adder_arbiter. Stimulus pushes the
// hand-computed {id, sum} of each operation it expects to complete. A
// monitor pops an entry at every response handshake and compares it. The
// monitor also checks response latency and exclusive readies.
module tb_shared_adder_arbiter;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_cin, req1_cin;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_sum;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [W:0] exp_q[$];

    // monitor bookkeeping
    int acc_cnt      = 0;
    int last_acc_cyc = -100;
    int last_hs_cyc  = -100;
    bit prev_valid   = 1'b0;
    bit per_chk      = 1'b0;
    bit have_prev    = 1'b0;

    // the external combinational adder the DUT drives
    assign add_sum = add_a + add_b + {{(W-1){1'b0}}, add_cin};

    shared_adder_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: response scoreboard, latency, exclusive readies, accept period.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_exclusive", {63'd0, req0_ready & req1_ready}, 64'd0);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                if (per_chk && have_prev)
                    check("accept_period", cyc - last_acc_cyc, 64'd3);
                have_prev    = 1'b1;
                last_acc_cyc = cyc;
                acc_cnt++;
            end
            if (rsp_valid && !prev_valid)
                check("rsp_latency", cyc - last_acc_cyc, 64'd2);
            if (rsp_valid && rsp_ready) begin
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    check("rsp_id", {63'd0, rsp_id}, {63'd0, e[W]});
                    check("rsp_sum", {32'd0, rsp_sum}, {32'd0, e[W-1:0]});
                end
            end
            prev_valid = rsp_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", {63'd0, exp_q.size() != 0}, 64'd0);
        @(posedge clk); #1;
    endtask

    // Drive one request until accepted; waits = cycles spent before ready.
    task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit cin, input logic [W-1:0] exp_sum, output int waits);
        bit seen;
        seen  = 1'b0;
        waits = 0;
        exp_q.push_back({id, exp_sum});
        if (id) begin
            req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
        end
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) == 1'b1) seen = 1'b1;
            else waits++;
        end
        check("accept_timeout", {63'd0, seen}, 64'd1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    initial begin
        int w;
        int start;
        int n;
        bit ok;
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_sum", {32'd0, rsp_sum}, 64'd0);
        check("rst_rsp_id", {63'd0, rsp_id}, 64'd0);
        check("rst_add_a", {32'd0, add_a}, 64'd0);
        check("rst_add_b", {32'd0, add_b}, 64'd0);
        check("rst_add_cin", {63'd0, add_cin}, 64'd0);
        check("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
        @(posedge clk); #1;

        // basic single request: 5+7+1
        issue(1'b0, 32'd5, 32'd7, 1'b1, 32'd13, w);
        check("req0_ready_immediate", w, 64'd0);
        drain();
        // carry-out discarded
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, w);
        drain();
        issue(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, w);
        drain();
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, w);
        drain();
        issue(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, w);
        drain();
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, w);
        drain();

        // back-pressure: result held for 4 cycles, no accepts meanwhile
        rsp_ready = 1'b0;
        issue(1'b0, 32'd100, 32'd23, 1'b0, 32'd123, w);
        exp_q.push_back({1'b1, 32'd2});
        req1_a = 32'd1; req1_b = 32'd1; req1_cin = 1'b0; req1_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = rsp_valid;
        end
        check("stall_rsp_timeout", {63'd0, ok}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("stall_rsp_sum", {32'd0, rsp_sum}, 64'd123);
            check("stall_rsp_id", {63'd0, rsp_id}, 64'd0);
            check("stall_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_release_req1_ready", {63'd0, req1_ready}, 64'd1);
        check("accept_after_hs", cyc - last_hs_cyc, 64'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drain();

        // contested requesters after reset: 0,1,0,1 every 3 cycles
        pulse_reset();
        req0_a = 32'd1;  req0_b = 32'd2;  req0_cin = 1'b0;
        req1_a = 32'd10; req1_b = 32'd20; req1_cin = 1'b1;
        exp_q.push_back({1'b0, 32'd3});
        exp_q.push_back({1'b1, 32'd31});
        exp_q.push_back({1'b0, 32'd3});
        exp_q.push_back({1'b1, 32'd31});
        per_chk = 1'b1; have_prev = 1'b0;
        start = acc_cnt;
        req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0;
        while (acc_cnt < start + 4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("contest_accepts", acc_cnt - start, 64'd4);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        per_chk = 1'b0;
        drain();

        // reset during EXEC: in-flight op dropped, contested re-grant to 0
        pulse_reset();
        req0_a = 32'd3; req0_b = 32'd4; req0_cin = 1'b0;
        req1_a = 32'd9; req1_b = 32'd9; req1_cin = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = req0_ready;
        end
        check("pre_rst_grant0", {63'd0, ok}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.push_back({1'b0, 32'd7});
        exp_q.push_back({1'b1, 32'd19});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("exec_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("exec_rst_rsp_sum", {32'd0, rsp_sum}, 64'd0);
        check("exec_rst_rsp_id", {63'd0, rsp_id}, 64'd0);
        check("exec_rst_add", {31'd0, add_cin, add_a | add_b}, 64'd0);
        check("exec_rst_regrant", {62'd0, req1_ready, req0_ready}, 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = req1_ready;
        end
        check("post_rst_req1_accept", {63'd0, ok}, 64'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drain();

        check("scoreboard_empty", exp_q.size(), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shared_adder_arbiter.md
SHARED_ADDER_ARBITER -- requirements
Module: shared_adder_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/sum width of the shared adder.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req0_valid  input  1  requester 0 has an add operation pending.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 Port: req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-007 Port: req0_cin  input  1  requester 0 carry-in.
REQ-008 Port: req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as REQ-004..007 for requester 1.
REQ-009 Port: add_a, add_b  output  WIDTH  operands driven to the external combinational adder.
REQ-010 Port: add_cin  output  1  carry-in driven to the external adder.
REQ-011 Port: add_sum  input  WIDTH  sum returned by the external adder (combinational).
REQ-012 Port: rsp_valid  output  1  result held in rsp_sum/rsp_id.
REQ-013 Port: rsp_ready  input  1  consumer takes result this cycle when high with rsp_valid.
REQ-014 Port: rsp_id  output  1  index of requester that issued the result.
REQ-015 Port: rsp_sum  output  WIDTH  registered result.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; one operation in flight at most.
REQ-017 Grant (combinational, IDLE only): only req0_valid -> 0; only req1_valid -> 1; both -> requester != last_grant; none -> no grant.
REQ-018 reqX_ready SHALL be high only in IDLE and only for the granted requester; never both high.
REQ-019 Accept (IDLE, granted valid&ready): register granted a/b/cin into add_a/add_b/add_cin, register id, set last_grant = id, go EXEC.
REQ-020 EXEC: capture add_sum into rsp_sum, id into rsp_id, go RESP; lasts exactly one cycle.
REQ-021 RESP: rsp_valid = 1; rsp_sum/rsp_id stable; rsp_ready high -> IDLE at next edge, else stay RESP.
REQ-022 Latency: accept at cycle N -> rsp_valid first high in cycle N+2.
REQ-023 No request SHALL be accepted in EXEC or RESP; new accept earliest in cycle after rsp handshake.
REQ-024 Sum is add_a + add_b + add_cin modulo 2^WIDTH; carry-out discarded (all-ones + 0 + 1 -> 0).
REQ-025 add_a/add_b/add_cin SHALL hold last issued values outside EXEC.
REQ-026 Requester deasserting valid without handshake SHALL not be accepted; no change to last_grant.
REQ-027 rsp_valid SHALL be 0 in IDLE and EXEC.

Reset
REQ-028 rst high at a rising edge, in any state: state = IDLE, rsp_valid = 0, rsp_sum = 0, rsp_id = 0, add_a = add_b = 0, add_cin = 0, last_grant = 1.
REQ-029 In-flight operation at reset SHALL be discarded; no rsp_valid produced for it.
REQ-030 First contested grant after reset SHALL go to requester 0.

Verification
REQ-031 Single req0 a=5,b=7,cin=1, rsp_ready=1 -> req0_ready in cycle 0, rsp_valid cycle 2, rsp_sum=13, rsp_id=0.
REQ-032 req0 and req1 valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; accepts every 3 cycles.
REQ-033 a=0xFFFFFFFF,b=0,cin=1 -> rsp_sum=0x00000000.
REQ-034 rsp_ready=0 for 4 cycles in RESP -> rsp_valid, rsp_sum, rsp_id stable; both reqX_ready=0; release -> IDLE next cycle.
REQ-035 rst asserted in EXEC -> next cycle IDLE, rsp_valid=0, all outputs 0; pending request re-granted to requester 0 if contested.
